// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types and constants for the parking occupancy counter.
// Revision : 1.0
// ============================================================================
package parking_pkg;

  localparam int COUNT_W     = 5;
  localparam int DEFAULT_CAP = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E1   = 3'd1,
    S_E2   = 3'd2,
    S_E3   = 3'd3,
    S_X1   = 3'd4,
    S_X2   = 3'd5,
    S_X3   = 3'd6,
    S_ERR  = 3'd7
  } gate_state_t;

endpackage : parking_pkg
`default_nettype wire

// File: rtl/sensor_sync.sv
`default_nettype none
// ============================================================================
// Module   : sensor_sync
// Purpose  : Multi-flop synchronizer for one asynchronous sensor bit.
// Revision : 1.0
// ============================================================================
module sensor_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= d;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
      end
    end
  endgenerate

  assign q = r_sync[SYNC_STAGES-1];

endmodule : sensor_sync
`default_nettype wire

// File: rtl/parking_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : parking_occupancy_counter
// Purpose  : Decodes gate sensor sequences into a saturating occupancy count.
// Revision : 1.0
// ============================================================================
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAP         = DEFAULT_CAP,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic [COUNT_W-1:0] counterstate,
  output logic               enter_pulse,
  output logic               exit_pulse,
  output logic               full,
  output logic               empty
);

  localparam logic [COUNT_W-1:0] c_cap  = COUNT_W'(CAP);
  localparam logic [COUNT_W-1:0] c_one  = COUNT_W'(1);

  logic              w_sa;
  logic              w_sb;
  logic [1:0]        w_pins;
  gate_state_t       r_state;
  gate_state_t       w_next_state;
  logic              w_entry_evt;
  logic              w_exit_evt;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;
  logic              w_enter;
  logic              w_exit;
  logic              r_enter;
  logic              r_exit;
  logic              r_full;
  logic              r_empty;

  sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (a),
    .q     (w_sa)
  );

  sensor_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (b),
    .q     (w_sb)
  );

  assign w_pins = {w_sa, w_sb};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Any input pattern not named for a state leaves that state unchanged.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        case (w_pins)
          2'b10:   w_next_state = S_E1;
          2'b01:   w_next_state = S_X1;
          2'b11:   w_next_state = S_ERR;
          default: w_next_state = r_state;
        endcase
      end
      S_E1: begin
        case (w_pins)
          2'b11:   w_next_state = S_E2;
          2'b00:   w_next_state = S_IDLE;
          2'b01:   w_next_state = S_ERR;
          default: w_next_state = r_state;
        endcase
      end
      S_E2: begin
        case (w_pins)
          2'b01:   w_next_state = S_E3;
          2'b10:   w_next_state = S_E1;
          2'b00:   w_next_state = S_ERR;
          default: w_next_state = r_state;
        endcase
      end
      S_E3: begin
        case (w_pins)
          2'b00:   w_next_state = S_IDLE;
          2'b11:   w_next_state = S_E2;
          2'b10:   w_next_state = S_ERR;
          default: w_next_state = r_state;
        endcase
      end
      S_X1: begin
        case (w_pins)
          2'b11:   w_next_state = S_X2;
          2'b00:   w_next_state = S_IDLE;
          2'b10:   w_next_state = S_ERR;
          default: w_next_state = r_state;
        endcase
      end
      S_X2: begin
        case (w_pins)
          2'b10:   w_next_state = S_X3;
          2'b01:   w_next_state = S_X1;
          2'b00:   w_next_state = S_ERR;
          default: w_next_state = r_state;
        endcase
      end
      S_X3: begin
        case (w_pins)
          2'b00:   w_next_state = S_IDLE;
          2'b11:   w_next_state = S_X2;
          2'b01:   w_next_state = S_ERR;
          default: w_next_state = r_state;
        endcase
      end
      S_ERR: begin
        if (w_pins == 2'b00) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Events fire on the same edge that the FSM returns to IDLE.
  always_comb begin
    w_entry_evt = 1'b0;
    w_exit_evt  = 1'b0;
    if (w_pins == 2'b00) begin
      w_entry_evt = (r_state == S_E3);
      w_exit_evt  = (r_state == S_X3);
    end
  end

  always_comb begin
    w_count_next = r_count;
    w_enter      = 1'b0;
    w_exit       = 1'b0;
    if (w_entry_evt && (r_count != c_cap)) begin
      w_count_next = r_count + c_one;
      w_enter      = 1'b1;
    end else if (w_exit_evt && (r_count != '0)) begin
      w_count_next = r_count - c_one;
      w_exit       = 1'b1;
    end
  end

  // Flags are derived from the next count so they track counterstate exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_next;
      r_enter <= w_enter;
      r_exit  <= w_exit;
      r_full  <= (w_count_next == c_cap);
      r_empty <= (w_count_next == '0);
    end
  end

  assign counterstate = r_count;
  assign enter_pulse  = r_enter;
  assign exit_pulse   = r_exit;
  assign full         = r_full;
  assign empty        = r_empty;

endmodule : parking_occupancy_counter
`default_nettype wire

// File: tb/tb_parking_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_occupancy_counter
// Purpose  : Directed and randomised checks of the parking occupancy counter.
// Revision : 1.0
// ============================================================================
module tb_parking_occupancy_counter;
  import parking_pkg::*;

  localparam int CAP = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [4:0] counterstate;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;
  int n_enter  = 0;
  int n_exit   = 0;
  int n_both   = 0;

  gate_state_t m_state = S_IDLE;
  int          m_count = 0;
  int          m_enter = 0;
  int          m_exit  = 0;

  parking_occupancy_counter #(.CAP(CAP), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .counterstate (counterstate),
    .enter_pulse  (enter_pulse),
    .exit_pulse   (exit_pulse),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enter_pulse === 1'b1) n_enter++;
    if (exit_pulse === 1'b1) n_exit++;
    if (enter_pulse === 1'b1 && exit_pulse === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [1:0] p);
    gate_state_t n;
    logic        ent;
    logic        ext;
    n   = m_state;
    ent = 1'b0;
    ext = 1'b0;
    case (m_state)
      S_IDLE: if (p == 2'b10) n = S_E1; else if (p == 2'b01) n = S_X1; else if (p == 2'b11) n = S_ERR;
      S_E1:   if (p == 2'b11) n = S_E2; else if (p == 2'b00) n = S_IDLE; else if (p == 2'b01) n = S_ERR;
      S_E2:   if (p == 2'b01) n = S_E3; else if (p == 2'b10) n = S_E1; else if (p == 2'b00) n = S_ERR;
      S_E3:   if (p == 2'b00) begin n = S_IDLE; ent = 1'b1; end
              else if (p == 2'b11) n = S_E2; else if (p == 2'b10) n = S_ERR;
      S_X1:   if (p == 2'b11) n = S_X2; else if (p == 2'b00) n = S_IDLE; else if (p == 2'b10) n = S_ERR;
      S_X2:   if (p == 2'b10) n = S_X3; else if (p == 2'b01) n = S_X1; else if (p == 2'b00) n = S_ERR;
      S_X3:   if (p == 2'b00) begin n = S_IDLE; ext = 1'b1; end
              else if (p == 2'b11) n = S_X2; else if (p == 2'b01) n = S_ERR;
      default: if (p == 2'b00) n = S_IDLE;
    endcase
    m_state = n;
    if (ent && m_count < CAP) begin m_count++; m_enter++; end
    if (ext && m_count > 0) begin m_count--; m_exit++; end
  endtask

  // Each pin pattern is held 4 cycles, long enough for the FSM to settle.
  task automatic drive(input logic pa, input logic pb);
    a = pa;
    b = pb;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) model_step({pa, pb});
  endtask

  task automatic do_entry();
    drive(1, 0); drive(1, 1); drive(0, 1); drive(0, 0);
  endtask

  task automatic do_exit();
    drive(0, 1); drive(1, 1); drive(1, 0); drive(0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a = 1'b0;
    b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_state = S_IDLE;
    m_count = 0;
  endtask

  initial begin
    int e0, x0, sel, len;

    // Reset state
    do_reset();
    check("rst_count", counterstate, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_enter", enter_pulse, 0);
    check("rst_exit", exit_pulse, 0);
    check("rst_state", dut.r_state, S_IDLE);

    // First entry with edge-accurate latency
    e0 = n_enter;
    drive(1, 0); drive(1, 1); drive(0, 1);
    a = 1'b0; b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_edge2_count", counterstate, 0);
    check("lat_edge2_pulse", enter_pulse, 0);
    @(posedge clk); #1;
    check("lat_edge3_pulse", enter_pulse, 1);
    check("lat_edge3_count", counterstate, 1);
    check("lat_edge3_empty", empty, 0);
    @(posedge clk); #1;
    check("lat_edge4_pulse", enter_pulse, 0);
    drive(0, 0);
    check("entry1_npulse", n_enter - e0, 1);

    // Two more entries, then one exit
    do_entry(); do_entry();
    check("entry3_count", counterstate, 3);
    e0 = n_enter; x0 = n_exit;
    do_exit();
    check("exit_count", counterstate, 2);
    check("exit_npulse", n_exit - x0, 1);
    check("exit_no_enter", n_enter - e0, 0);

    // Aborted entry and invalid jump through ERR
    e0 = n_enter; x0 = n_exit;
    drive(1, 0); drive(1, 1); drive(1, 0); drive(0, 0);
    check("abort_count", counterstate, 2);
    check("abort_state", dut.r_state, S_IDLE);
    drive(1, 0); drive(0, 1);
    check("err_state", dut.r_state, S_ERR);
    drive(0, 0);
    check("err_count", counterstate, 2);
    check("err_idle", dut.r_state, S_IDLE);
    check("abort_err_pulses", (n_enter - e0) + (n_exit - x0), 0);

    // Fill to capacity, then saturate
    for (int i = 0; i < 14; i++) do_entry();
    check("cap_count", counterstate, CAP);
    check("cap_full", full, 1);
    e0 = n_enter;
    do_entry();
    check("sat_count", counterstate, CAP);
    check("sat_full", full, 1);
    check("sat_no_pulse", n_enter - e0, 0);

    // Exit from empty lot
    do_reset();
    x0 = n_exit;
    do_exit();
    check("empty_exit_count", counterstate, 0);
    check("empty_exit_flag", empty, 1);
    check("empty_exit_no_pulse", n_exit - x0, 0);

    // Reset while in E3 with five cars counted
    for (int i = 0; i < 5; i++) do_entry();
    check("pre_e3_count", counterstate, 5);
    drive(1, 0); drive(1, 1); drive(0, 1);
    check("in_e3", dut.r_state, S_E3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_count", counterstate, 0);
    check("midrst_state", dut.r_state, S_IDLE);
    reset = 1'b0;
    m_state = S_IDLE;
    m_count = 0;
    e0 = n_enter;
    drive(0, 0);
    check("midrst_release_count", counterstate, 0);
    check("midrst_release_pulse", n_enter - e0, 0);

    // Random legal and illegal sequences against the model
    e0 = n_enter; x0 = n_exit;
    m_enter = 0; m_exit = 0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 4);
      if (sel <= 1) begin
        do_entry();
      end else if (sel == 2) begin
        do_exit();
      end else begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      check("rnd_count", counterstate, m_count);
      check("rnd_range", (counterstate <= CAP), 1);
      check("rnd_full", full, (m_count == CAP));
      check("rnd_empty", empty, (m_count == 0));
    end
    check("rnd_enter_total", n_enter - e0, m_enter);
    check("rnd_exit_total", n_exit - x0, m_exit);
    check("pulses_exclusive", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_parking_occupancy_counter
`default_nettype wire
